// File: rtl/gcd_pkg.sv
// Shared types and defaults for the gcd requester and its timeout timer.
package gcd_pkg;

    localparam int GCD_DEFAULT_WIDTH   = 8;
    localparam int GCD_DEFAULT_TIMEOUT = 2**GCD_DEFAULT_WIDTH + 8;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_ISSUE,
        REQ_WAIT,
        REQ_DONE
    } gcd_req_state_t;

endpackage

// File: rtl/gcd_req_timer.sv
// Saturating WAIT-cycle timer; flags the last allowed WAIT cycle.
module gcd_req_timer
    import gcd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = GCD_DEFAULT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_count;

    // Holds at TIMEOUT_CYCLES so a stalled enable can never wrap back to a live count.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != TW'(TIMEOUT_CYCLES))) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_terminal = (r_count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gcd_requester.sv
// Initiator for a gcd core: issues one operand pair at a time, waits for the
// core's completion edge or a timeout, then hands the result downstream.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH          = GCD_DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 2**WIDTH + 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [WIDTH-1:0]     req_a_i,
    input  logic [WIDTH-1:0]     req_b_i,
    output logic                 core_valid_o,
    output logic [WIDTH-1:0]     core_a_o,
    output logic [WIDTH-1:0]     core_b_o,
    input  logic                 core_valid_i,
    input  logic [WIDTH-1:0]     core_gcd_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [WIDTH-1:0]     rsp_gcd_o,
    output logic                 rsp_timeout_o,
    output logic [CNT_WIDTH-1:0] txn_count_o
);

    gcd_req_state_t       r_state;
    logic                 r_core_valid;
    logic [WIDTH-1:0]     r_core_a;
    logic [WIDTH-1:0]     r_core_b;
    logic                 r_core_valid_prev;
    logic                 r_rsp_valid;
    logic [WIDTH-1:0]     r_rsp_gcd;
    logic                 r_rsp_timeout;
    logic [CNT_WIDTH-1:0] r_txn_count;

    logic w_req_fire;
    logic w_rsp_fire;
    logic w_core_edge;
    logic w_timer_clear;
    logic w_timer_enable;
    logic w_timer_terminal;

    assign req_ready_o    = (r_state == REQ_IDLE) && reset_ni;
    assign w_req_fire     = req_valid_i && req_ready_o;
    assign w_rsp_fire     = r_rsp_valid && rsp_ready_i;
    assign w_core_edge    = core_valid_i && !r_core_valid_prev;
    assign w_timer_clear  = (r_state == REQ_ISSUE);
    assign w_timer_enable = (r_state == REQ_WAIT);

    gcd_req_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk      (clk_i),
        .i_reset_n  (reset_ni),
        .i_clear    (w_timer_clear),
        .i_enable   (w_timer_enable),
        .o_terminal (w_timer_terminal)
    );

    // The core's valid stays high from its last result, so only a fresh rising edge counts.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_core_valid_prev <= 1'b0;
        end else begin
            r_core_valid_prev <= core_valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= REQ_IDLE;
            r_core_valid  <= 1'b0;
            r_core_a      <= '0;
            r_core_b      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_gcd     <= '0;
            r_rsp_timeout <= 1'b0;
            r_txn_count   <= '0;
        end else begin
            r_core_valid <= 1'b0;
            case (r_state)
                REQ_IDLE: begin
                    if (w_req_fire) begin
                        r_core_a     <= req_a_i;
                        r_core_b     <= req_b_i;
                        r_core_valid <= 1'b1;
                        r_state      <= REQ_ISSUE;
                    end
                end
                REQ_ISSUE: begin
                    r_state <= REQ_WAIT;
                end
                REQ_WAIT: begin
                    // A result arriving on the terminal cycle still beats the timeout.
                    if (w_core_edge) begin
                        r_rsp_gcd     <= core_gcd_i;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= REQ_DONE;
                    end else if (w_timer_terminal) begin
                        r_rsp_gcd     <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= REQ_DONE;
                    end
                end
                REQ_DONE: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 1'b0;
                        r_txn_count <= r_txn_count + CNT_WIDTH'(1);
                        r_state     <= REQ_IDLE;
                    end
                end
                default: begin
                    r_state <= REQ_IDLE;
                end
            endcase
        end
    end

    assign core_valid_o  = r_core_valid;
    assign core_a_o      = r_core_a;
    assign core_b_o      = r_core_b;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_gcd_o     = r_rsp_gcd;
    assign rsp_timeout_o = r_rsp_timeout;
    assign txn_count_o   = r_txn_count;

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: a behavioural gcd core stub with programmable
// latency drives the core side; results are checked against plain arithmetic.
module tb_gcd_requester;

    localparam int W  = 8;
    localparam int TO = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstN;
    logic          reqValid;
    logic          reqReady;
    logic [W-1:0]  reqA;
    logic [W-1:0]  reqB;
    logic          coreValidO;
    logic [W-1:0]  coreA;
    logic [W-1:0]  coreB;
    logic          stubValid = 1'b0;
    logic [W-1:0]  stubGcd = '0;
    logic          rspValid;
    logic          rspReady;
    logic [W-1:0]  rspGcd;
    logic          rspTimeout;
    logic [CW-1:0] txnCount;

    int errors = 0;
    int checks = 0;
    int expCount = 0;
    int pulseCount = 0;

    int           stubMode = 0;
    int           stubLat = 0;
    logic         stubPending = 1'b0;
    int           stubCount = 0;
    logic [W-1:0] stubA = '0;
    logic [W-1:0] stubB = '0;

    always #5 clk = ~clk;

    gcd_requester #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (rstN),
        .req_valid_i   (reqValid),
        .req_ready_o   (reqReady),
        .req_a_i       (reqA),
        .req_b_i       (reqB),
        .core_valid_o  (coreValidO),
        .core_a_o      (coreA),
        .core_b_o      (coreB),
        .core_valid_i  (stubValid),
        .core_gcd_i    (stubGcd),
        .rsp_valid_o   (rspValid),
        .rsp_ready_i   (rspReady),
        .rsp_gcd_o     (rspGcd),
        .rsp_timeout_o (rspTimeout),
        .txn_count_o   (txnCount)
    );

    function automatic logic [W-1:0] gcdModel(input logic [W-1:0] a, input logic [W-1:0] b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    function automatic logic [W-1:0] stubCompute(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a;
        logic [W-1:0] y = b;
        if (x == 0) return y;
        if (y == 0) return x;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return x;
    endfunction

    // Core stub: valid drops in the START cycle, rises stubLat cycles later (mode 0) or never (mode 1).
    always @(posedge clk) begin
        if (coreValidO) begin
            stubValid   <= 1'b0;
            stubA       <= coreA;
            stubB       <= coreB;
            stubPending <= (stubMode == 0);
            stubCount   <= stubLat;
        end else if (stubPending) begin
            if (stubCount == 0) begin
                stubValid   <= 1'b1;
                stubGcd     <= stubCompute(stubA, stubB);
                stubPending <= 1'b0;
            end else begin
                stubCount <= stubCount - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (coreValidO) pulseCount <= pulseCount + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, waits for its response, then handshakes after readyDelay stall cycles.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int readyDelay,
                                 output logic [W-1:0] gotGcd, output logic gotTimeout,
                                 output int gotLat, output bit hung);
        int n;
        hung       = 1'b0;
        gotGcd     = '0;
        gotTimeout = 1'b0;
        gotLat     = 0;
        reqA       = a;
        reqB       = b;
        reqValid   = 1'b1;
        n = 0;
        while (!reqReady && n < 100) begin
            step();
            n++;
        end
        step();
        reqValid = 1'b0;
        gotLat = 1;
        while (!rspValid && gotLat < 100) begin
            step();
            gotLat++;
        end
        if (!rspValid) begin
            hung = 1'b1;
            return;
        end
        gotGcd     = rspGcd;
        gotTimeout = rspTimeout;
        repeat (readyDelay) step();
        rspReady = 1'b1;
        step();
        rspReady = 1'b0;
    endtask

    task automatic test_reset();
        rstN     = 1'b1;
        reqValid = 1'b0;
        reqA     = '0;
        reqB     = '0;
        rspReady = 1'b0;
        #3 rstN = 1'b0;
        #4;
        checks++;
        if (reqReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready_low: got %0b expected 0", reqReady);
        end
        checks++;
        if ({coreValidO, coreA, coreB, rspValid, rspGcd, rspTimeout, txnCount} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got cv=%0b a=%0d b=%0d rv=%0b g=%0d to=%0b cnt=%0d expected all 0",
                     coreValidO, coreA, coreB, rspValid, rspGcd, rspTimeout, txnCount);
        end
        repeat (2) step();
        #3 rstN = 1'b1;
        step();
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %0b expected 1", reqReady);
        end
        checks++;
        if (rspValid !== 1'b0 || txnCount !== '0) begin
            errors++;
            $display("[TB] FAIL reset_release_idle: got rv=%0b cnt=%0d expected rv=0 cnt=0", rspValid, txnCount);
        end
        expCount = 0;
    endtask

    task automatic test_basic();
        logic [W-1:0] g;
        logic         t;
        int           lat;
        bit           hung;
        int           p0;
        stubMode = 0;
        stubLat  = 3;
        p0 = pulseCount;
        applyStimulus(8'd6, 8'd2, 0, g, t, lat, hung);
        expCount++;
        checks++;
        if (hung) begin
            errors++;
            $display("[TB] FAIL basic_response: got none expected a response within bound");
        end
        checks++;
        if (g !== 8'd2 || t !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_gcd: got gcd=%0d to=%0b expected gcd=2 to=0", g, t);
        end
        checks++;
        if (lat != stubLat + 4) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, stubLat + 4);
        end
        checks++;
        if (pulseCount - p0 != 1) begin
            errors++;
            $display("[TB] FAIL basic_pulse_width: got %0d cycles expected 1", pulseCount - p0);
        end
        checks++;
        if (txnCount !== CW'(expCount)) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d expected %0d", txnCount, expCount);
        end
    endtask

    task automatic test_latency();
        logic [W-1:0] g;
        logic         t;
        int           lat;
        bit           hung;
        stubMode = 0;
        stubLat  = 0;
        applyStimulus(8'd7, 8'd7, 0, g, t, lat, hung);
        expCount++;
        checks++;
        if (hung || lat != 4) begin
            errors++;
            $display("[TB] FAIL min_latency: got %0d cycles (hung=%0b) expected 4", lat, hung);
        end
        checks++;
        if (g !== 8'd7 || t !== 1'b0) begin
            errors++;
            $display("[TB] FAIL min_latency_gcd: got gcd=%0d to=%0b expected gcd=7 to=0", g, t);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] results[$];
        int cyc      = 0;
        int accepted = 0;
        int seen     = 0;
        int hs1      = -1;
        int pulse2   = -1;
        bit fire;
        stubMode = 0;
        stubLat  = 2;
        reqA     = 8'd9;
        reqB     = 8'd12;
        reqValid = 1'b1;
        rspReady = 1'b1;
        while (results.size() < 2 && cyc < 200) begin
            if (coreValidO) begin
                seen++;
                if (seen == 2) pulse2 = cyc;
            end
            if (rspValid && rspReady) begin
                results.push_back(rspGcd);
                if (hs1 < 0) hs1 = cyc;
            end
            fire = reqValid && reqReady;
            step();
            cyc++;
            if (fire) begin
                accepted++;
                if (accepted == 1) begin
                    reqA = 8'd18;
                    reqB = 8'd12;
                end else begin
                    reqValid = 1'b0;
                end
            end
        end
        reqValid = 1'b0;
        rspReady = 1'b0;
        expCount += results.size();
        checks++;
        if (results.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d responses expected 2", results.size());
        end else begin
            checks++;
            if (results[0] !== 8'd3 || results[1] !== 8'd6) begin
                errors++;
                $display("[TB] FAIL b2b_order: got %0d,%0d expected 3,6", results[0], results[1]);
            end
        end
        checks++;
        if (pulse2 <= hs1) begin
            errors++;
            $display("[TB] FAIL b2b_second_issue: got pulse cycle %0d expected after handshake cycle %0d", pulse2, hs1);
        end
        checks++;
        if (txnCount !== CW'(expCount)) begin
            errors++;
            $display("[TB] FAIL b2b_txn_count: got %0d expected %0d", txnCount, expCount);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int p0;
        stubMode = 0;
        stubLat  = 1;
        reqA     = 8'd0;
        reqB     = 8'd5;
        reqValid = 1'b1;
        rspReady = 1'b0;
        while (!rspValid && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (rspValid !== 1'b1 || rspGcd !== 8'd5 || rspTimeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_operand: got rv=%0b gcd=%0d to=%0b expected rv=1 gcd=5 to=0", rspValid, rspGcd, rspTimeout);
        end
        p0 = pulseCount;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (rspValid !== 1'b1 || rspGcd !== 8'd5) begin
                errors++;
                $display("[TB] FAIL stall_hold: got rv=%0b gcd=%0d expected rv=1 gcd=5", rspValid, rspGcd);
            end
            checks++;
            if (reqReady !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_ready: got %0b expected 0", reqReady);
            end
        end
        checks++;
        if (pulseCount != p0) begin
            errors++;
            $display("[TB] FAIL stall_no_issue: got %0d extra pulses expected 0", pulseCount - p0);
        end
        reqValid = 1'b0;
        rspReady = 1'b1;
        step();
        rspReady = 1'b0;
        expCount++;
        checks++;
        if (txnCount !== CW'(expCount) || rspValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: got cnt=%0d rv=%0b expected cnt=%0d rv=0", txnCount, rspValid, expCount);
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] g;
        logic         t;
        int           lat;
        bit           hung;

        stubMode = 1;
        applyStimulus(8'd10, 8'd4, 0, g, t, lat, hung);
        expCount++;
        checks++;
        if (hung || g !== 8'd0 || t !== 1'b1 || lat != TO + 2) begin
            errors++;
            $display("[TB] FAIL timeout_basic: got gcd=%0d to=%0b lat=%0d hung=%0b expected gcd=0 to=1 lat=%0d",
                     g, t, lat, hung, TO + 2);
        end

        stubMode = 0;
        stubLat  = TO - 2;
        applyStimulus(8'd12, 8'd8, 1, g, t, lat, hung);
        expCount++;
        checks++;
        if (hung || g !== 8'd4 || t !== 1'b0 || lat != TO + 2) begin
            errors++;
            $display("[TB] FAIL timeout_tie_result_wins: got gcd=%0d to=%0b lat=%0d expected gcd=4 to=0 lat=%0d",
                     g, t, lat, TO + 2);
        end

        stubLat = TO - 1;
        applyStimulus(8'd12, 8'd8, 0, g, t, lat, hung);
        expCount++;
        checks++;
        if (hung || g !== 8'd0 || t !== 1'b1 || lat != TO + 2) begin
            errors++;
            $display("[TB] FAIL timeout_late_edge: got gcd=%0d to=%0b lat=%0d expected gcd=0 to=1 lat=%0d",
                     g, t, lat, TO + 2);
        end
        checks++;
        if (txnCount !== CW'(expCount)) begin
            errors++;
            $display("[TB] FAIL timeout_count: got %0d expected %0d", txnCount, expCount);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
        logic [W-1:0] expG;
        logic         t;
        logic         expT;
        int           lat;
        int           expLat;
        int           d;
        bit           hung;
        stubMode = 0;
        for (int i = 0; i < 24; i++) begin
            a       = W'($urandom_range(0, 255));
            b       = W'($urandom_range(0, 255));
            stubLat = $urandom_range(0, TO + 1);
            d       = $urandom_range(0, 3);
            // Completion is seen in WAIT cycle stubLat+2; it must land within TO WAIT cycles.
            if (stubLat + 2 <= TO) begin
                expG   = gcdModel(a, b);
                expT   = 1'b0;
                expLat = stubLat + 4;
            end else begin
                expG   = '0;
                expT   = 1'b1;
                expLat = TO + 2;
            end
            applyStimulus(a, b, d, g, t, lat, hung);
            expCount++;
            checks++;
            if (hung || g !== expG || t !== expT || lat != expLat) begin
                errors++;
                $display("[TB] FAIL random_txn: a=%0d b=%0d lat_cfg=%0d got gcd=%0d to=%0b lat=%0d expected gcd=%0d to=%0b lat=%0d",
                         a, b, stubLat, g, t, lat, expG, expT, expLat);
            end
        end
        checks++;
        if (txnCount !== CW'(expCount)) begin
            errors++;
            $display("[TB] FAIL random_count: got %0d expected %0d", txnCount, expCount);
        end
    endtask

    task automatic test_reset_midwait();
        logic [W-1:0] g;
        logic         t;
        int           lat;
        bit           hung;
        stubMode = 1;
        reqA     = 8'd33;
        reqB     = 8'd11;
        reqValid = 1'b1;
        step();
        reqValid = 1'b0;
        repeat (3) step();
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (reqReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midwait_reset_ready: got %0b expected 0", reqReady);
        end
        checks++;
        if ({coreValidO, coreA, coreB, rspValid, rspGcd, rspTimeout, txnCount} !== '0) begin
            errors++;
            $display("[TB] FAIL midwait_reset_outputs: got cv=%0b a=%0d b=%0d rv=%0b g=%0d to=%0b cnt=%0d expected all 0",
                     coreValidO, coreA, coreB, rspValid, rspGcd, rspTimeout, txnCount);
        end
        #2 rstN = 1'b1;
        expCount = 0;
        step();
        checks++;
        if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midwait_release: got ready=%0b rv=%0b expected ready=1 rv=0", reqReady, rspValid);
        end
        stubMode = 0;
        stubLat  = 3;
        applyStimulus(8'd18, 8'd12, 0, g, t, lat, hung);
        expCount++;
        checks++;
        if (hung || g !== 8'd6 || t !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midwait_recovery: got gcd=%0d to=%0b hung=%0b expected gcd=6 to=0", g, t, hung);
        end
        checks++;
        if (txnCount !== CW'(expCount)) begin
            errors++;
            $display("[TB] FAIL midwait_count: got %0d expected %0d", txnCount, expCount);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_midwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd_requester.md
Name: gcd_requester

Overview:
Initiator side of the gcd core's operand/result interface. It accepts operand pairs from an upstream valid/ready stream and issues each pair to a gcd core as a single-cycle valid pulse. It waits for the core's result with a timeout guard, then returns the result downstream on a valid/ready stream. It sits between the system datapath and the gcd instance and owns all sequencing of that core.

Parameters:
WIDTH, 8, operand and result width; must match the attached gcd core
TIMEOUT_CYCLES, 2**WIDTH+8, number of WAIT cycles before the transaction is abandoned; must be >= 1
CNT_WIDTH, 16, width of the completed-transaction counter

Ports:
clk_i  in  1  clock, rising edge
reset_ni  in  1  asynchronous, active-low reset
req_valid_i  in  1  upstream operand pair valid
req_ready_o  out  1  requester can accept a pair
req_a_i  in  WIDTH  operand a
req_b_i  in  WIDTH  operand b
core_valid_o  out  1  one-cycle start pulse to the core's valid_i
core_a_o  out  WIDTH  to the core's a_i
core_b_o  out  WIDTH  to the core's b_i
core_valid_i  in  1  from the core's valid_o; level signal, held high after completion
core_gcd_i  in  WIDTH  from the core's gcd_o
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  downstream accepts result
rsp_gcd_o  out  WIDTH  result; 0 on timeout
rsp_timeout_o  out  1  1 = transaction timed out
txn_count_o  out  CNT_WIDTH  completed responses, wraps modulo 2**CNT_WIDTH

Behaviour:
- Clock, reset and reset values:
  - One clock domain, clk_i. Reset is asynchronous and active-low on reset_ni.
  - Every flop clears immediately on reset_ni low: state=IDLE, core_valid_o=0, core_a_o=0, core_b_o=0, rsp_valid_o=0, rsp_gcd_o=0, rsp_timeout_o=0, txn_count_o=0, timer=0, edge register=0.
  - req_ready_o is forced 0 while reset_ni is low.
  - Reset in any state abandons the transaction; the next cycle after release is IDLE.
- req_ready_o = (state==IDLE) and reset_ni high. It is combinational from state only and does not depend on req_valid_i.
- States:
  - IDLE: on req_valid_i && req_ready_o, register req_a_i/req_b_i into core_a_o/core_b_o, then go to ISSUE.
  - ISSUE: core_valid_o=1 for exactly this one cycle (registered output). Clear the timer. Next state is WAIT.
  - WAIT:
    - Increment the timer each cycle.
    - On a rising edge of core_valid_i (current 1, previous-cycle 0): rsp_gcd_o<=core_gcd_i, rsp_timeout_o<=0, go to DONE.
    - Else if timer reaches TIMEOUT_CYCLES-1: rsp_gcd_o<=0, rsp_timeout_o<=1, go to DONE.
    - If the edge and the timeout coincide, the result wins.
  - DONE: rsp_valid_o=1. rsp_gcd_o and rsp_timeout_o are held stable until rsp_ready_i. On the handshake cycle: go to IDLE, txn_count_o+1 (wraps), rsp_valid_o<=0.
- core_a_o/core_b_o are held constant from ISSUE until the next acceptance in IDLE. The core samples them in the ISSUE cycle.
- Edge detection:
  - The core's valid_o stays high from the previous result until the core's START cycle, which is the cycle after ISSUE. A level check is therefore forbidden; only a rising edge seen in WAIT completes a transaction.
  - The previous-value register for core_valid_i updates every cycle in every state.
  - Edges in IDLE, ISSUE or DONE are discarded.
- Latency: request accepted in cycle T gives ISSUE in T+1 and rsp_valid_o high in T+4 at the earliest (case a==b). Throughput is one transaction in flight; there is no queuing.
- After a timeout the core is not reset by this block; recovering the core is the integrator's responsibility. A late result from the core is discarded unless it lands in a subsequent WAIT.
- Width rules: data is passed through unmodified. The timer is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.

Decomposition:
- Package gcd_pkg holds:
  - typedef enum logic[1:0] gcd_req_state_t {REQ_IDLE, REQ_ISSUE, REQ_WAIT, REQ_DONE};
  - localparam GCD_DEFAULT_TIMEOUT.
- One sub-module: gcd_req_timer (clear, enable, terminal-count flag; parameter TIMEOUT_CYCLES). Everything else stays in gcd_requester.

Test Plan:
- (6,2) with the real gcd core, rsp_ready_i=1 -> rsp_gcd_o=2, rsp_timeout_o=0, txn_count_o=1, core_valid_o high exactly one cycle.
- (7,7) accepted in cycle T -> rsp_valid_o first high in T+4, rsp_gcd_o=7.
- Back-to-back (9,12) then (18,12), req_valid_i held high -> results 3 then 6 in order. Second core_valid_o pulse occurs only after the first response handshake. txn_count_o=2.
- (0,5) -> rsp_gcd_o=5. Then hold rsp_ready_i=0 for 10 cycles with req_valid_i=1 -> rsp_valid_o/rsp_gcd_o stable, req_ready_o=0, no new core_valid_o pulse.
- TIMEOUT_CYCLES=16 with a stub holding core_valid_i=0 -> rsp_valid_o after 16 WAIT cycles with rsp_gcd_o=0, rsp_timeout_o=1. Stub edge in the same cycle as terminal count -> result reported, timeout=0.
- reset_ni low mid-WAIT (asynchronous, between clock edges) -> all outputs to reset values immediately. After release, req_ready_o=1 and a new (18,12) request returns 6.
